alu_sequencer: RTL

//  Command-driven controller that sequences one alu and one accumulator register (external instances).
//  - Accepts one command per valid/ready handshake.
//  - Drives the register control strobes and the alu operands for the required number of cycles.
//  - Returns the final accumulator value on a result handshake.

---
 rtl/alu_seq_pkg.sv | 29 ++
 rtl/seq_counter.sv | 36 +++
 rtl/alu_sequencer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_seq_pkg                                                                |
// | Shared widths, command mode encodings and FSM state type for alu_sequencer.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package alu_seq_pkg;

  localparam int DEF_W   = 4;
  localparam int DEF_OCW = 3;
  localparam int CNT_W   = 4;

  localparam logic [1:0] MODE_LOAD  = 2'b00;
  localparam logic [1:0] MODE_ALU   = 2'b01;
  localparam logic [1:0] MODE_SHIFT = 2'b10;
  localparam logic [1:0] MODE_STEP  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_EXEC  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_CLEAR = 3'd4,
    ST_STEP  = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seq_counter                                                                |
// | Loadable down-counter with zero flag; sizes SHIFT and STEP bursts.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module seq_counter #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          zero
);

  logic [CW-1:0] r_count;

  // Decrement saturates at zero so a stray dec never wraps the burst length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign count = r_count;
  assign zero  = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_sequencer                                                              |
// | Command FSM driving an external alu and accumulator register strobes.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int W   = DEF_W,
  parameter int OCW = DEF_OCW
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [1:0]     cmd_mode,
  input  logic [OCW-1:0] cmd_oc,
  input  logic [W-1:0]   cmd_op,
  output logic [OCW-1:0] alu_oc,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  input  logic [W-1:0]   alu_f,
  output logic           acc_cl,
  output logic           acc_ld,
  output logic           acc_inc,
  output logic           acc_dec,
  output logic           acc_sr,
  output logic           acc_ir,
  output logic           acc_sl,
  output logic           acc_il,
  output logic [W-1:0]   acc_in,
  input  logic [W-1:0]   acc_out,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [W-1:0]   res_data
);

  state_t           r_state;
  state_t           w_next_state;
  logic [1:0]       r_mode;
  logic [OCW-1:0]   r_oc;
  logic [W-1:0]     r_op;
  logic             r_res_valid;

  logic             w_accept;
  logic             w_cnt_load;
  logic [CNT_W-1:0] w_cnt_val;
  logic             w_cnt_dec;
  logic [CNT_W-1:0] w_cnt_count;
  logic             w_cnt_zero;

  seq_counter #(
    .CW (CNT_W)
  ) u_seq_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_cnt_load),
    .load_val (w_cnt_val),
    .dec      (w_cnt_dec),
    .count    (w_cnt_count),
    .zero     (w_cnt_zero)
  );

  assign w_accept  = cmd_valid && (r_state == ST_IDLE);
  assign cmd_ready = (r_state == ST_IDLE);
  assign res_valid = r_res_valid;
  assign res_data  = r_res_valid ? acc_out : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_mode  <= 2'b00;
      r_oc    <= '0;
      r_op    <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_mode <= cmd_mode;
        r_oc   <= cmd_oc;
        r_op   <= cmd_op;
      end
    end
  end

  // Result is presented one cycle after entering DONE, giving accept-to-valid of N+1 edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_valid <= 1'b0;
    end else if (r_res_valid && res_ready) begin
      r_res_valid <= 1'b0;
    end else if (r_state == ST_DONE) begin
      r_res_valid <= 1'b1;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_cnt_load   = 1'b0;
    w_cnt_val    = '0;
    w_cnt_dec    = 1'b0;
    alu_oc       = '0;
    alu_a        = '0;
    alu_b        = '0;
    acc_in       = '0;
    acc_cl       = 1'b0;
    acc_ld       = 1'b0;
    acc_inc      = 1'b0;
    acc_dec      = 1'b0;
    acc_sr       = 1'b0;
    acc_ir       = 1'b0;
    acc_sl       = 1'b0;
    acc_il       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (cmd_mode)
            MODE_LOAD: w_next_state = ST_LOAD;
            MODE_ALU:  w_next_state = ST_EXEC;
            MODE_SHIFT: begin
              w_cnt_load   = 1'b1;
              w_cnt_val    = CNT_W'(cmd_oc);
              w_next_state = (w_cnt_val == '0) ? ST_DONE : ST_SHIFT;
            end
            default: begin
              if (cmd_oc[2]) begin
                w_next_state = ST_CLEAR;
              end else begin
                w_cnt_load   = 1'b1;
                w_cnt_val    = CNT_W'(cmd_op);
                w_next_state = (w_cnt_val == '0) ? ST_DONE : ST_STEP;
              end
            end
          endcase
        end
      end

      ST_LOAD: begin
        acc_ld       = 1'b1;
        acc_in       = r_op;
        w_next_state = ST_DONE;
      end

      ST_EXEC: begin
        alu_oc       = r_oc;
        alu_a        = acc_out;
        alu_b        = r_op;
        acc_in       = alu_f;
        acc_ld       = 1'b1;
        w_next_state = ST_DONE;
      end

      ST_CLEAR: begin
        acc_cl       = 1'b1;
        w_next_state = ST_DONE;
      end

      ST_SHIFT: begin
        if (!w_cnt_zero) begin
          w_cnt_dec = 1'b1;
          if (r_op[2]) begin
            acc_sl = 1'b1;
            acc_il = r_op[3];
          end else begin
            acc_sr = 1'b1;
            acc_ir = r_op[3];
          end
        end
        // Leave on the pulse that takes the count from 1 to 0.
        if (w_cnt_count <= CNT_W'(1)) begin
          w_next_state = ST_DONE;
        end
      end

      ST_STEP: begin
        if (!w_cnt_zero) begin
          w_cnt_dec = 1'b1;
          if (r_oc[0]) begin
            acc_dec = 1'b1;
          end else begin
            acc_inc = 1'b1;
          end
        end
        if (w_cnt_count <= CNT_W'(1)) begin
          w_next_state = ST_DONE;
        end
      end

      ST_DONE: begin
        if (r_res_valid && res_ready) begin
          w_next_state = ST_IDLE;
        end
      end

      default: w_next_state = ST_IDLE;
    endcase
  end

  logic w_unused;
  assign w_unused = ^r_mode;

endmodule
`default_nettype wire
